// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage, instruction memory and decode.
// master = fetch stage side, slave = memory/decode environment side.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Every valid/ready pair transfers exactly on a clock edge where both are high;
  // valid may drop without a transfer and nothing is sampled while ready is low.
  // The response channel has no ready: it always transfers when rsp_valid is high.
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, in-order memory requests,
// a show-ahead instruction buffer toward decode, and redirect with stale-response discard.
module fetch_unit #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fetch_unit_if.master                bus,
  output logic [1:0]                  o_state,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [FIFO_DEPTH];

  logic [CNT_W:0]    w_credit_sum;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp_ok;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_inflight_next;
  logic [CNT_W-1:0]  w_drop_next;
  logic [ADDR_W-1:0] w_redirect_pc;

  // Requests are only issued while every in-flight word is guaranteed a buffer slot.
  assign w_credit_sum    = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_req_valid     = (r_state == FETCH) && !bus.redirect_valid && (w_credit_sum < DEPTH_L);
  assign w_req_fire      = w_req_valid && bus.imem_req_ready;
  assign w_rsp_ok        = bus.imem_rsp_valid && (r_outstanding != '0);
  assign w_push          = w_rsp_ok && (r_drop_cnt == '0) && !bus.redirect_valid;
  assign w_pop           = (r_count != '0) && bus.inst_ready;
  assign w_inflight_next = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_ok);
  assign w_redirect_pc   = bus.redirect_pc & ~ADDR_W'(3);

  // Everything still in flight after a redirect belongs to the old path.
  always_comb begin
    w_drop_next = r_drop_cnt;
    if (bus.redirect_valid) begin
      w_drop_next = w_inflight_next;
    end else if (w_rsp_ok && (r_drop_cnt != '0)) begin
      w_drop_next = r_drop_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:         w_state_next = FETCH;
      FETCH, FLUSH: w_state_next = (w_drop_next != '0) ? FLUSH : FETCH;
      default:      w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_inflight_next;
      r_drop_cnt    <= w_drop_next;
      if (bus.redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + ADDR_W'(4);
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= bus.imem_rsp_data;
      r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = (r_count != '0);
  assign bus.inst_data      = r_mem_data[r_rd_ptr];
  assign bus.inst_pc        = r_mem_pc[r_rd_ptr];
  assign o_state            = r_state;
  assign o_fifo_count       = r_count;

  // A response with nothing outstanding is a memory-side protocol violation.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.imem_rsp_valid && (r_outstanding == '0)));
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder, decode sink and scoreboard,
// directed reset/stream/backpressure/redirect/wrap/reset cases and a random phase.
module tb_fetch_unit;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] dbg_state;
  logic [2:0] dbg_count;

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .o_state      (dbg_state),
    .o_fifo_count (dbg_count)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];   // {pc, data} expected at decode, in order
  logic [63:0] pend[$];    // {due cycle, addr} memory requests awaiting response
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  int cyc = 0;
  int last_due = 0;
  int acc_total = 0;
  int pop_total = 0;
  int first_acc_cyc = -1;
  int first_pop_cyc = -1;
  int redir_inflight = 0;

  logic        ctl_req_ready = 1'b1;
  logic        ctl_inst_ready = 1'b1;
  logic        ctl_redirect = 1'b0;
  logic [31:0] ctl_redirect_pc = '0;
  logic        ctl_rand = 1'b0;
  int          ctl_lat = 1;

  typedef struct {
    logic [31:0] rpc;
    int          lat;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } redir_vec_t;
  redir_vec_t vecs[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // ---------------- driver: memory responder, decode sink, scoreboard ----------------
  initial begin
    int lat;
    int due;
    logic [63:0] e;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.imem_req_ready = ctl_rand ? ($urandom_range(0, 3) != 0) : ctl_req_ready;
      bus.inst_ready     = ctl_rand ? ($urandom_range(0, 1) == 1) : ctl_inst_ready;
      bus.redirect_valid = ctl_redirect;
      bus.redirect_pc    = ctl_redirect_pc;
      if (!rst_n) begin
        pend.delete();
        exp_q.delete();
        last_due = 0;
        bus.imem_rsp_valid = 1'b0;
      end else if (pend.size() != 0 && int'(pend[0][63:32]) <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pend[0][31:0]);
        void'(pend.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
      end
      #1;
      if (rst_n) begin
        if (bus.inst_valid && bus.inst_ready) begin
          pop_total++;
          pop_log.push_back(bus.inst_pc);
          if (first_pop_cyc < 0) first_pop_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=%h required=none", {bus.inst_pc, bus.inst_data});
          end else begin
            e = exp_q.pop_front();
            check("sb_inst", {bus.inst_pc, bus.inst_data}, e);
          end
        end
        if (bus.redirect_valid) begin
          check("redirect_req_gated", 64'(bus.imem_req_valid), 64'd0);
          exp_q.delete();
          redir_inflight = pend.size();
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          lat = ctl_rand ? int'($urandom_range(1, 4)) : ctl_lat;
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back({32'(due), bus.imem_req_addr});
          exp_q.push_back({bus.imem_req_addr, mem_word(bus.imem_req_addr)});
          acc_log.push_back(bus.imem_req_addr);
          acc_total++;
          if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic clear_logs();
    acc_log.delete();
    pop_log.delete();
    acc_total = 0;
    pop_total = 0;
    first_acc_cyc = -1;
    first_pop_cyc = -1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_logs(input int na, input int np, input string name);
    int n = 0;
    while ((acc_log.size() < na || pop_log.size() < np) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) timeout_fail(name);
  endtask

  task automatic wait_count(input logic [2:0] want, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (dbg_count != want && n < 60);
    if (dbg_count != want) timeout_fail(name);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    @(posedge clk);
    ctl_redirect    = 1'b1;
    ctl_redirect_pc = pc;
    @(posedge clk);
    ctl_redirect    = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int p0;
    int n;
    vecs[0] = '{32'h0000_0103, 3, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    vecs[1] = '{32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h0000_0002, 2, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    vecs[3] = '{32'hABCD_0007, 4, 32'hABCD_0004, 32'hABCD_0008, 32'hABCD_000C};
    vecs[4] = '{32'hFFFF_FFFF, 2, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    // Reset held for three edges, then the first three fetch addresses.
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst_fifo_count", 64'(dbg_count), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    @(negedge clk); #2;
    check("post_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("post_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    wait_logs(3, 3, "t1_wait");
    for (int i = 0; i < 3; i++) begin
      check("t1_addr", 64'((acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF), 64'(32'(4 * i)));
    end

    // Streaming at latency 1: two-cycle fetch-to-decode latency, one instruction per cycle.
    check("t2_min_latency", 64'(first_pop_cyc - first_acc_cyc), 64'd2);
    repeat (5) @(posedge clk);
    p0 = pop_total;
    repeat (20) @(posedge clk);
    check("t2_rate", 64'(pop_total - p0), 64'd20);
    @(negedge clk); #2;
    check("t2_push_pop_count", 64'(dbg_count), 64'd1);

    // Backpressure from decode: exactly the buffer depth of requests, then issue stops.
    ctl_inst_ready = 1'b0;
    do_reset(2);
    repeat (15) @(posedge clk);
    @(negedge clk); #2;
    check("t3_accepted", 64'(acc_total), 64'd4);
    check("t3_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("t3_full_count", 64'(dbg_count), 64'd4);
    check("t3_head_pc", 64'(bus.inst_pc), 64'd0);
    check("t3_head_data", 64'(bus.inst_data), 64'(mem_word(32'h0)));
    ctl_inst_ready = 1'b1;
    n = 0;
    while (acc_total <= 4 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("t3_resume", 64'(acc_total > 4), 64'd1);

    // Push and pop in the same cycle hold occupancy, then the buffer fills completely.
    ctl_inst_ready = 1'b0;
    ctl_lat = 4;
    do_reset(2);
    wait_count(3'd2, "t6_wait_two");
    ctl_inst_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    ctl_inst_ready = 1'b0;
    @(negedge clk); #2;
    check("t6_simul_count", 64'(dbg_count), 64'd3);
    wait_count(3'd4, "t6_wait_full");
    check("t6_full_count", 64'(dbg_count), 64'd4);
    check("t6_full_req_valid", 64'(bus.imem_req_valid), 64'd0);

    // Reset in the middle of a stream clears the buffer and restarts at the reset PC.
    ctl_inst_ready = 1'b1;
    ctl_lat = 2;
    repeat (10) @(posedge clk);
    do_reset(1);
    @(negedge clk); #2;
    check("t6_rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("t6_rst_count", 64'(dbg_count), 64'd0);
    check("t6_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    wait_logs(1, 1, "t6_rst_wait");
    check("t6_rst_pc", 64'((acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF), 64'd0);

    // Redirect table: alignment, wrap-around and stale-response discard.
    foreach (vecs[v]) begin
      ctl_lat = vecs[v].lat;
      ctl_inst_ready = 1'b1;
      repeat (12) @(posedge clk);
      pulse_redirect(vecs[v].rpc);
      clear_logs();
      @(negedge clk); #2;
      check("redir_state", 64'(dbg_state), 64'((redir_inflight > 0) ? ST_FLUSH : ST_FETCH));
      wait_logs(3, 3, "redir_wait");
      check("redir_addr0", 64'((acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF), 64'(vecs[v].e0));
      check("redir_addr1", 64'((acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_BEEF), 64'(vecs[v].e1));
      check("redir_addr2", 64'((acc_log.size() > 2) ? acc_log[2] : 32'hDEAD_BEEF), 64'(vecs[v].e2));
      check("redir_pc0", 64'((pop_log.size() > 0) ? pop_log[0] : 32'hDEAD_BEEF), 64'(vecs[v].e0));
      check("redir_pc1", 64'((pop_log.size() > 1) ? pop_log[1] : 32'hDEAD_BEEF), 64'(vecs[v].e1));
      check("redir_pc2", 64'((pop_log.size() > 2) ? pop_log[2] : 32'hDEAD_BEEF), 64'(vecs[v].e2));
    end

    // Random ready, latency and occasional redirects; the scoreboard checks every delivery.
    ctl_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) pulse_redirect($urandom);
      else @(posedge clk);
    end
    ctl_rand = 1'b0;
    ctl_req_ready = 1'b0;
    ctl_inst_ready = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk); #2;
    check("drain_exp_empty", 64'(exp_q.size()), 64'd0);
    check("drain_count", 64'(dbg_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
